// File: rtl/fifo_write_arbiter.sv
// ============================================================================
// Module   : fifo_write_arbiter
// Purpose  : Round-robin write arbiter sharing one fifo_pll write port among
//            NUM_REQ valid/ready producers, with credit-based full protection
//            and optional burst locking (up to MAX_BURST beats per grant).
// Ports    : clk, rst (async, active-low)
//            req_valid[NUM_REQ], req_data[NUM_REQ*WIDTH] -> req_ready[NUM_REQ]
//            fifo_pop (one pulse per FIFO read)
//            fifo_write_enable, fifo_data_in (registered, latency 1)
//            credits (free FIFO entries as seen by the arbiter)
//            grant_count[NUM_REQ*16] (only with FIFO_ARB_STATS_EN defined)
// Options  : FIFO_ARB_STATS_EN - per-producer saturating transfer counters
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_write_arbiter #(
    parameter int WIDTH      = 16,
    parameter int NUM_REQ    = 4,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int MAX_BURST  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     fifo_pop,
    output logic                     fifo_write_enable,
    output logic [WIDTH-1:0]         fifo_data_in,
`ifdef FIFO_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0]    grant_count,
`endif
    output logic [ADDR_WIDTH:0]      credits
);

    localparam int                  IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [3:0]          BURST_C = 4'(MAX_BURST);
    localparam logic                LOCK_EN = (MAX_BURST > 1);

    // IDLE = unlocked, BURST = port locked to owner
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   last;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   rr_idx;
    logic [3:0]      beat_cnt;
    logic            rr_found;
    logic            burst_hit;
    logic            owner_valid;
    logic            transfer;
    int              j;

    // Round-robin search starting just after the last granted producer.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        j        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(last) + k) % NUM_REQ;
            if (!rr_found && req_valid[j]) begin
                rr_found = 1'b1;
                rr_idx   = IW'(j);
            end
        end
    end

    assign owner_valid = req_valid[owner];
    // A burst that has reached MAX_BURST beats no longer keeps the port.
    assign burst_hit   = (state == BURST) && owner_valid && (beat_cnt < BURST_C);
    assign winner      = burst_hit ? owner : rr_idx;
    // rst is folded in so req_ready is zero while reset is asserted.
    assign transfer    = rst && (credits != '0) && (burst_hit || rr_found);
    assign req_ready   = transfer ? (NUM_REQ'(1) << winner) : '0;

    always_comb begin
        state_next = state;
        if (transfer) begin
            state_next = LOCK_EN ? BURST : IDLE;
        end else if ((credits != '0) && (!owner_valid || (beat_cnt >= BURST_C))) begin
            // With zero credits the lock is held so the owner resumes first.
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last              <= IW'(NUM_REQ - 1);
            owner             <= '0;
            beat_cnt          <= '0;
            credits           <= DEPTH_C;
            fifo_write_enable <= 1'b0;
            fifo_data_in      <= '0;
        end else begin
            fifo_write_enable <= transfer;
            if (transfer) begin
                fifo_data_in <= req_data[winner*WIDTH +: WIDTH];
                last         <= winner;
                // burst_hit implies winner == owner while locked
                if (burst_hit) begin
                    beat_cnt <= beat_cnt + 4'd1;
                end else begin
                    owner    <= winner;
                    beat_cnt <= 4'd1;
                end
            end
            if (transfer && !fifo_pop) begin
                credits <= credits - 1'b1;
            end else if (!transfer && fifo_pop && (credits != DEPTH_C)) begin
                credits <= credits + 1'b1;
            end
        end
    end

`ifdef FIFO_ARB_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        logic [15:0] cnt;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt <= '0;
            end else if (req_ready[g] && (cnt != 16'hFFFF)) begin
                cnt <= cnt + 16'd1;
            end
        end
        assign grant_count[g*16 +: 16] = cnt;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
// ============================================================================
// Module   : tb_fifo_write_arbiter
// Purpose  : Self-checking bench for fifo_write_arbiter. Two instances
//            (MAX_BURST=4 and MAX_BURST=1) share stimulus; each is compared
//            cycle by cycle against a behavioural model, plus directed steps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_write_arbiter;

    localparam int W = 16;
    localparam int N = 4;
    localparam int D = 8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic        fifo_pop;
    logic [3:0]  rdy0, rdy1;
    logic        we0, we1;
    logic [15:0] din0, din1;
    logic [3:0]  cr0, cr1;
`ifdef FIFO_ARB_STATS_EN
    logic [63:0] gc0, gc1;
`endif

    fifo_write_arbiter #(.WIDTH(W), .NUM_REQ(N), .DEPTH(D), .ADDR_WIDTH(3), .MAX_BURST(4)) u_b4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy0), .fifo_pop(fifo_pop), .fifo_write_enable(we0),
        .fifo_data_in(din0),
`ifdef FIFO_ARB_STATS_EN
        .grant_count(gc0),
`endif
        .credits(cr0));

    fifo_write_arbiter #(.WIDTH(W), .NUM_REQ(N), .DEPTH(D), .ADDR_WIDTH(3), .MAX_BURST(1)) u_b1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy1), .fifo_pop(fifo_pop), .fifo_write_enable(we1),
        .fifo_data_in(din1),
`ifdef FIFO_ARB_STATS_EN
        .grant_count(gc1),
`endif
        .credits(cr1));

    int vectors = 0;
    int miscompares = 0;

    // Reference model state, index 0 = MAX_BURST 4, index 1 = MAX_BURST 1
    int          mb[2] = '{4, 1};
    int          m_last[2], m_owner[2], m_beats[2], m_locked[2], m_cred[2], m_we[2];
    logic [15:0] m_data[2];
    int          m_cnt[2][4];
    int          gw[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_last[i] = N - 1; m_owner[i] = 0; m_beats[i] = 0; m_locked[i] = 0;
            m_cred[i] = D; m_we[i] = 0; m_data[i] = '0;
            for (int k = 0; k < N; k++) m_cnt[i][k] = 0;
        end
    endtask

    function automatic int model_winner(int i);
        if (!rst || m_cred[i] == 0) return -1;
        if (m_locked[i] != 0 && req_valid[m_owner[i]] && m_beats[i] < mb[i]) return m_owner[i];
        for (int k = 1; k <= N; k++)
            if (req_valid[(m_last[i] + k) % N]) return (m_last[i] + k) % N;
        return -1;
    endfunction

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int          w;
            logic [3:0]  er;
            w  = model_winner(i);
            gw[i] = w;
            er = (w < 0) ? 4'b0 : (4'b1 << w);
            check(i == 0 ? "b4_ready" : "b1_ready", i == 0 ? rdy0 : rdy1, er);
            check(i == 0 ? "b4_we"    : "b1_we",    i == 0 ? we0  : we1,  m_we[i]);
            check(i == 0 ? "b4_data"  : "b1_data",  i == 0 ? din0 : din1, m_data[i]);
            check(i == 0 ? "b4_cred"  : "b1_cred",  i == 0 ? cr0  : cr1,  m_cred[i]);
`ifdef FIFO_ARB_STATS_EN
            for (int k = 0; k < N; k++)
                check("grant_cnt", i == 0 ? gc0[k*16 +: 16] : gc1[k*16 +: 16], m_cnt[i][k]);
`endif
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int w;
            w = gw[i];
            if (w >= 0) begin
                m_we[i]   = 1;
                m_data[i] = req_data[w*16 +: 16];
                if (m_locked[i] != 0 && w == m_owner[i] && m_beats[i] < mb[i]) m_beats[i]++;
                else begin m_owner[i] = w; m_beats[i] = 1; end
                m_locked[i] = (mb[i] > 1) ? 1 : 0;
                m_last[i]   = w;
                if (m_cnt[i][w] < 65535) m_cnt[i][w]++;
            end else begin
                m_we[i] = 0;
                if (m_cred[i] != 0 && (!req_valid[m_owner[i]] || m_beats[i] >= mb[i])) m_locked[i] = 0;
            end
            if (w >= 0 && !fifo_pop) m_cred[i]--;
            else if (w < 0 && fifo_pop && m_cred[i] < D) m_cred[i]++;
        end
    endtask

    // One clock: drive at the falling edge, check, advance the model.
    task automatic cycle(input logic [3:0] v, input logic [63:0] d, input logic pop);
        @(negedge clk);
        req_valid = v; req_data = d; fifo_pop = pop;
        #1;
        check_all();
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; req_valid = '0; fifo_pop = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        int         exp1[12] = '{0, 1, 2, 3, 0, 1, 2, 3, -1, -1, -1, -1};
        int         exp2[9]  = '{1, 1, 1, 1, 2, 2, 2, 2, 1};
        int         wcount;
        logic [3:0] onehot;
        logic [63:0] d;

        rst = 1'b1; req_valid = '0; req_data = '0; fifo_pop = 1'b0;
        model_reset();

        // Reset values and all-valid round robin on the MAX_BURST=1 instance
        do_reset();
        wcount = 0;
        for (int c = 0; c < 12; c++) begin
            cycle(4'hF, rnd64(), 1'b0);
            onehot = (exp1[c] < 0) ? 4'b0 : (4'b1 << exp1[c]);
            check("t1_rr_grant", rdy1, onehot);
            wcount += int'(we1);
        end
        cycle(4'h0, rnd64(), 1'b0);
        wcount += int'(we1);
        check("t1_write_pulses", wcount, 8);

        // Burst locking with continuous pops
        do_reset();
        for (int c = 0; c < 9; c++) begin
            cycle(4'b0110, rnd64(), 1'b1);
            check("t2_burst_grant", rdy0, 4'b1 << exp2[c]);
            check("t2_credits", cr0, D);
        end

        // Zero credits, then a pop re-enables req3 one cycle later
        do_reset();
        for (int c = 0; c < 8; c++) cycle(4'hF, rnd64(), 1'b0);
        cycle(4'b1000, rnd64(), 1'b1);
        check("t3_no_grant", rdy0, 4'b0);
        d = rnd64();
        cycle(4'b1000, d, 1'b0);
        check("t3_ready3", rdy0, 4'b1000);
        check("t3_ready3_b1", rdy1, 4'b1000);
        cycle(4'b0000, rnd64(), 1'b0);
        check("t3_we", we0, 1'b1);
        check("t3_data", din0, d[63:48]);

        // Simultaneous transfer and pop at credits=5
        do_reset();
        for (int c = 0; c < 3; c++) cycle(4'b0001, rnd64(), 1'b0);
        cycle(4'b0001, rnd64(), 1'b1);
        check("t4_cred_before", cr0, 4'd5);
        cycle(4'b0000, rnd64(), 1'b0);
        check("t4_cred_after", cr0, 4'd5);

        // Owner drops valid mid-burst; lock moves to req2
        do_reset();
        cycle(4'b0101, rnd64(), 1'b0);
        cycle(4'b0101, rnd64(), 1'b0);
        cycle(4'b0100, rnd64(), 1'b0);
        check("t5_switch", rdy0, 4'b0100);
        cycle(4'b0101, rnd64(), 1'b0);
        check("t5_lock_moved", rdy0, 4'b0100);

        // Pop with a full credit count saturates at DEPTH
        do_reset();
        cycle(4'b0000, rnd64(), 1'b1);
        cycle(4'b0000, rnd64(), 1'b0);
        check("t6_saturate", cr0, D);

`ifdef FIFO_ARB_STATS_EN
        do_reset();
        for (int c = 0; c < 10; c++) cycle(4'b0010, rnd64(), c >= 2);
        cycle(4'b0000, rnd64(), 1'b0);
        check("t7_count10", gc0[31:16], 16'd10);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t7_count_rst", gc0[31:16], 16'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
`endif

        // Randomized traffic with legal pops and occasional reset
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic pop;
            if ($urandom_range(0, 299) == 0) do_reset();
            pop = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < 2; i++)
                if (D - m_cred[i] - m_we[i] <= 0) pop = 1'b0;
            cycle(4'($urandom_range(0, 15)), rnd64(), pop);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
